// File: rtl/mem_access_unit.sv
// mem_access_unit: RV32I load/store unit driving a single-port, byte-strobed word memory.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned halves/words instead of force-aligning them.
module mem_access_unit #(
   parameter int TIMEOUT_CYC = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        lsu_valid,
   output logic        lsu_ready,
   input  logic        lsu_we,
   input  logic [2:0]  lsu_funct3,
   input  logic [31:0] lsu_addr,
   input  logic [31:0] lsu_wdata,
   output logic [31:0] lsu_rdata,
   output logic        lsu_done,
   output logic        lsu_err,
   input  logic        conf_sel,
   output logic        mem_wren,
   output logic        mem_rden,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

   localparam int CW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic          we_q, we_n;
   logic [2:0]    f3_q, f3_n;
   logic [1:0]    off_q, off_n;

   logic          done_n, err_n, wren_n, rden_n;
   logic [31:0]   rdata_n, addr_n, wdata_n;
   logic [3:0]    wstrb_n;

   logic          legal, trap;
   logic [1:0]    off_in;
   logic [3:0]    strb_in;
   logic [31:0]   wd_in, sh, ld;

   assign lsu_ready = (state == IDLE) & ~conf_sel;

   always_comb begin
      legal = 1'b0;
      unique case (lsu_funct3)
         3'b000, 3'b001, 3'b010: legal = 1'b1;
         3'b100, 3'b101:         legal = ~lsu_we;
         default:                legal = 1'b0;
      endcase
   end

`ifdef LSU_MISALIGN_TRAP_EN
   assign trap   = (lsu_funct3[1:0] == 2'b01 & lsu_addr[0]) |
                   (lsu_funct3[1:0] == 2'b10 & |lsu_addr[1:0]);
   assign off_in = lsu_addr[1:0];
`else
   // misaligned halves/words silently drop the low offset bits
   assign trap   = 1'b0;
   assign off_in = (lsu_funct3[1:0] == 2'b10) ? 2'b00 :
                   (lsu_funct3[1:0] == 2'b01) ? {lsu_addr[1], 1'b0} :
                   lsu_addr[1:0];
`endif

   always_comb begin
      strb_in = 4'b1111;
      wd_in   = lsu_wdata;
      unique case (lsu_funct3[1:0])
         2'b00: begin
            strb_in = 4'b0001 << off_in;
            wd_in   = {4{lsu_wdata[7:0]}};
         end
         2'b01: begin
            strb_in = 4'b0011 << off_in;
            wd_in   = {2{lsu_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   assign sh = mem_rdata >> {off_q, 3'b000};

   always_comb begin
      ld = mem_rdata;
      unique case (f3_q)
         3'b000:  ld = {{24{sh[7]}}, sh[7:0]};
         3'b001:  ld = {{16{sh[15]}}, sh[15:0]};
         3'b100:  ld = {24'h0, sh[7:0]};
         3'b101:  ld = {16'h0, sh[15:0]};
         default: ld = mem_rdata;
      endcase
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      we_n    = we_q;
      f3_n    = f3_q;
      off_n   = off_q;
      done_n  = 1'b0;
      err_n   = 1'b0;
      rdata_n = 32'h0;
      wren_n  = 1'b0;
      rden_n  = 1'b0;
      wstrb_n = 4'h0;
      addr_n  = mem_addr;
      wdata_n = mem_wdata;
      unique case (state)
         IDLE: begin
            if (lsu_valid & lsu_ready) begin
               we_n  = lsu_we;
               f3_n  = lsu_funct3;
               off_n = off_in;
               if (~legal | trap) begin
                  done_n  = 1'b1;
                  err_n   = 1'b1;
                  state_n = RESP;
               end else begin
                  // strobes are registered here so they show during REQ
                  state_n = REQ;
                  wren_n  = lsu_we;
                  rden_n  = ~lsu_we;
                  addr_n  = {2'b00, lsu_addr[31:2]};
                  if (lsu_we) begin
                     wstrb_n = strb_in;
                     wdata_n = wd_in;
                  end
               end
            end
         end
         REQ: begin
            state_n = WAIT;
            cnt_n   = '0;
         end
         WAIT: begin
            if (mem_ready) begin
               state_n = RESP;
               done_n  = 1'b1;
               rdata_n = we_q ? 32'h0 : ld;
            end else if (cnt == CNT_LAST) begin
               state_n = RESP;
               done_n  = 1'b1;
               err_n   = 1'b1;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         RESP: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt       <= '0;
         we_q      <= 1'b0;
         f3_q      <= 3'b0;
         off_q     <= 2'b0;
         lsu_done  <= 1'b0;
         lsu_err   <= 1'b0;
         lsu_rdata <= 32'h0;
         mem_wren  <= 1'b0;
         mem_rden  <= 1'b0;
         mem_addr  <= 32'h0;
         mem_wstrb <= 4'h0;
         mem_wdata <= 32'h0;
      end else begin
         cnt       <= cnt_n;
         we_q      <= we_n;
         f3_q      <= f3_n;
         off_q     <= off_n;
         lsu_done  <= done_n;
         lsu_err   <= err_n;
         lsu_rdata <= rdata_n;
         mem_wren  <= wren_n;
         mem_rden  <= rden_n;
         mem_addr  <= addr_n;
         mem_wstrb <= wstrb_n;
         mem_wdata <= wdata_n;
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed bench with a cycle-timeline model of mem_access_unit.
// Honours LSU_MISALIGN_TRAP_EN the same way the design does.
module tb_mem_access_unit;

   localparam int T = 15;
   localparam int N = 1024;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        lsu_valid = 1'b0;
   logic        lsu_ready;
   logic        lsu_we = 1'b0;
   logic [2:0]  lsu_funct3 = 3'b0;
   logic [31:0] lsu_addr = 32'h0;
   logic [31:0] lsu_wdata = 32'h0;
   logic [31:0] lsu_rdata;
   logic        lsu_done;
   logic        lsu_err;
   logic        conf_sel = 1'b0;
   logic        mem_wren, mem_rden;
   logic [31:0] mem_addr;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = 32'h0;
   logic        mem_ready = 1'b0;

   mem_access_unit #(.TIMEOUT_CYC(T)) dut (
      .clk(clk), .reset(reset),
      .lsu_valid(lsu_valid), .lsu_ready(lsu_ready),
      .lsu_we(lsu_we), .lsu_funct3(lsu_funct3),
      .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
      .lsu_rdata(lsu_rdata), .lsu_done(lsu_done), .lsu_err(lsu_err),
      .conf_sel(conf_sel),
      .mem_wren(mem_wren), .mem_rden(mem_rden),
      .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int compared = 0;
   int mismatched = 0;

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s cyc=%0d got=%h want=%h", n, cyc, act, exp);
      end
   endtask

   // expected output timeline, indexed by cycle
   bit        e_wren [N];
   bit        e_rden [N];
   bit        e_done [N];
   bit        e_err  [N];
   bit [31:0] e_addr [N];
   bit [3:0]  e_strb [N];
   bit [31:0] e_wdat [N];
   bit [31:0] e_rdat [N];
   int acc_c = -10;
   int done_c = -1;

   task automatic model_accept(input int c, input bit we, input bit [2:0] f3,
                               input bit [31:0] a, input bit [31:0] wd,
                               input bit [31:0] rw, input bit mute);
      int sz, off, d;
      bit bad;
      bit [31:0] v, ew;
      bit [3:0] es;
      sz = 1 << f3[1:0];
      bad = we ? (f3 > 3'd2) : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      off = int'(a[1:0]);
`ifdef LSU_MISALIGN_TRAP_EN
      if (!bad && (off % sz) != 0) bad = 1;
`else
      if (!bad) off = off - (off % sz);
`endif
      acc_c = c;
      if (bad) begin
         d = c + 1;
         e_err[d] = 1;
      end else begin
         e_wren[c+1] = we;
         e_rden[c+1] = !we;
         e_addr[c+1] = a >> 2;
         if (we) begin
            es = 0;
            ew = 0;
            for (int i = 0; i < 4; i++) begin
               if (i >= off && i < off + sz) es[i] = 1;
               ew[8*i +: 8] = wd[8*(i % sz) +: 8];
            end
            e_strb[c+1] = es;
            e_wdat[c+1] = ew;
         end
         if (mute) begin
            d = c + 2 + T;
            e_err[d] = 1;
         end else begin
            d = c + 4;
            if (!we) begin
               v = 0;
               for (int i = 0; i < sz; i++) v[8*i +: 8] = rw[8*(off + i) +: 8];
               if (!f3[2] && sz < 4 && v[8*sz-1])
                  for (int i = sz; i < 4; i++) v[8*i +: 8] = 8'hFF;
               e_rdat[d] = v;
            end
         end
      end
      e_done[d] = 1;
      done_c = d;
   endtask

   task automatic model_abort(input int k);
      for (int j = k; j < k + T + 6; j++) begin
         e_wren[j] = 0; e_rden[j] = 0; e_done[j] = 0; e_err[j] = 0;
         e_strb[j] = 0; e_rdat[j] = 0;
      end
      acc_c = k - 1;
      done_c = k - 1;
   endtask

   // memory: answers two cycles after a strobe unless muted
   bit [31:0] rd_word = 0;
   bit mem_mute = 0;
   int rdy_at = -1;
   always @(negedge clk)
      if ((mem_wren | mem_rden) && !mem_mute) rdy_at = cyc + 2;
   always @(posedge clk) begin
      #1;
      mem_ready = (cyc == rdy_at);
      mem_rdata = mem_ready ? rd_word : 32'h5A5A5A5A;
   end

   bit run = 0;
   always @(negedge clk) begin
      if (run && cyc < N) begin
         chk("ready", lsu_ready,
             !(cyc > acc_c && cyc <= done_c) && !conf_sel);
         chk("wren", mem_wren, e_wren[cyc]);
         chk("rden", mem_rden, e_rden[cyc]);
         chk("wstrb", mem_wstrb, e_strb[cyc]);
         chk("done", lsu_done, e_done[cyc]);
         chk("err", lsu_err, e_err[cyc]);
         chk("rdata", lsu_rdata, e_rdat[cyc]);
         if (e_wren[cyc] || e_rden[cyc]) chk("addr", mem_addr, e_addr[cyc]);
         if (e_wren[cyc]) chk("wdata", mem_wdata, e_wdat[cyc]);
      end
   end

   int o_str, o_done;
   logic o_err;
   logic [31:0] o_addr, o_wdata, o_rdata;
   logic [3:0] o_strb;

   task automatic do_req(input bit we, input bit [2:0] f3, input bit [31:0] a,
                         input bit [31:0] wd, input bit [31:0] rw,
                         input bit mute, input bit cs_mid);
      int c;
      lsu_we = we; lsu_funct3 = f3; lsu_addr = a; lsu_wdata = wd;
      rd_word = rw; mem_mute = mute;
      conf_sel = 0; lsu_valid = 1;
      c = cyc;
      model_accept(c, we, f3, a, wd, rw, mute);
      o_str = 0; o_done = -1; o_err = 0;
      o_addr = 0; o_wdata = 0; o_rdata = 0; o_strb = 0;
      @(posedge clk); #1;
      lsu_valid = 0;
      for (int i = 0; i < T + 6; i++) begin
         if (cs_mid && cyc == c + 2) conf_sel = 1;
         @(negedge clk);
         if (mem_wren | mem_rden) begin
            o_str++;
            o_addr = mem_addr; o_strb = mem_wstrb; o_wdata = mem_wdata;
         end
         if (lsu_done) begin
            o_done = cyc - c; o_err = lsu_err; o_rdata = lsu_rdata;
            break;
         end
         @(posedge clk); #1;
      end
      if (o_done < 0) chk("done_seen", 0, 1);
      @(posedge clk); #1;
      while (cyc <= done_c) begin @(posedge clk); #1; end
      conf_sel = 0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", lsu_ready, 1);
      chk("rst_done", lsu_done, 0);
      chk("rst_strb", {mem_wren, mem_rden, mem_wstrb}, 0);
      chk("rst_addr", mem_addr, 0);
      @(posedge clk); #1;
      reset = 0;
      run = 1;

      do_req(1, 3'b010, 32'h104, 32'hDEADBEEF, 0, 0, 0);
      chk("sw_addr", o_addr, 32'h41);
      chk("sw_strb", o_strb, 4'b1111);
      chk("sw_wdata", o_wdata, 32'hDEADBEEF);
      chk("sw_lat", o_done, 4);
      chk("sw_err", o_err, 0);

      do_req(1, 3'b000, 32'h103, 32'h000000A5, 0, 0, 0);
      chk("sb_strb", o_strb, 4'b1000);
      chk("sb_wdata", o_wdata, 32'hA5A5A5A5);
      do_req(0, 3'b000, 32'h103, 0, 32'hA5000000, 0, 0);
      chk("lb", o_rdata, 32'hFFFFFFA5);
      do_req(0, 3'b100, 32'h103, 0, 32'hA5000000, 0, 0);
      chk("lbu", o_rdata, 32'h000000A5);
      do_req(0, 3'b001, 32'h102, 0, 32'h80011234, 0, 0);
      chk("lh", o_rdata, 32'hFFFF8001);
      do_req(0, 3'b101, 32'h102, 0, 32'h80011234, 0, 0);
      chk("lhu", o_rdata, 32'h00008001);
      do_req(1, 3'b001, 32'h106, 32'h1234BEEF, 0, 0, 0);
      chk("sh_strb", o_strb, 4'b1100);
      do_req(0, 3'b010, 32'h108, 0, 32'h12345678, 0, 0);
      do_req(0, 3'b000, 32'h101, 0, 32'h00007F00, 0, 0);

      lsu_we = 0; lsu_funct3 = 3'b010; lsu_addr = 32'h10C;
      conf_sel = 1; lsu_valid = 1;
      repeat (10) begin @(posedge clk); #1; end
      @(negedge clk);
      chk("conf_ready", lsu_ready, 0);
      @(posedge clk); #1;
      do_req(0, 3'b010, 32'h10C, 0, 32'h0BADF00D, 0, 0);
      chk("conf_lat", o_done, 4);

      do_req(0, 3'b010, 32'h110, 0, 0, 1, 0);
      chk("to_lat", o_done, 2 + T);
      chk("to_err", o_err, 1);
      chk("to_strobes", o_str, 1);
      mem_mute = 0;

      do_req(0, 3'b011, 32'h120, 0, 0, 0, 0);
      chk("ill_lat", o_done, 1);
      chk("ill_str", o_str, 0);
      do_req(1, 3'b100, 32'h120, 32'h1, 0, 0, 0);
      chk("ill_st_err", o_err, 1);

      do_req(0, 3'b010, 32'h102, 0, 32'hCAFEF00D, 0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
      chk("mis_lat", o_done, 1);
      chk("mis_err", o_err, 1);
      chk("mis_str", o_str, 0);
`else
      chk("mis_addr", o_addr, 32'h40);
      chk("mis_lat", o_done, 4);
      chk("mis_rdata", o_rdata, 32'hCAFEF00D);
`endif
      do_req(0, 3'b001, 32'h103, 0, 32'h80011234, 0, 0);
      do_req(1, 3'b001, 32'h101, 32'h0000ABCD, 0, 0, 0);

      do_req(1, 3'b010, 32'h200, 32'h01020304, 0, 0, 1);
      chk("cs_mid_lat", o_done, 4);

      lsu_we = 0; lsu_funct3 = 3'b010; lsu_addr = 32'h300;
      rd_word = 32'h11112222; mem_mute = 0; lsu_valid = 1;
      c = cyc;
      model_accept(c, 0, 3'b010, 32'h300, 0, 32'h11112222, 0);
      @(posedge clk); #1;
      lsu_valid = 0;
      @(posedge clk); #1;
      reset = 1;
      model_abort(cyc);
      @(negedge clk);
      chk("rstw_strb", {mem_wren, mem_rden, mem_wstrb}, 0);
      chk("rstw_addr", mem_addr, 0);
      chk("rstw_wdata", mem_wdata, 0);
      chk("rstw_rdata", lsu_rdata, 0);
      chk("rstw_ready", lsu_ready, 1);
      @(posedge clk); #1;
      reset = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("rstw_nodone", lsu_done, 0);
      end
      @(posedge clk); #1;

      do_req(0, 3'b100, 32'h301, 0, 32'h0000C300, 0, 0);
      chk("post_rst_lbu", o_rdata, 32'h000000C3);

      run = 0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store unit between the RV32I core's execute stage and the single-port CPU side of the instruction/data memory. Converts byte/half/word loads and stores into word-addressed, byte-strobed memory requests. Waits for the memory's ready pulse, then returns sign- or zero-extended load data. Stalls while the memory is in configuration mode and times out if the memory never answers.

## Interface
- `TIMEOUT_CYC`, default 15: cycles spent in WAIT without `mem_ready` before the transaction is aborted with an error.
- `clk`  in  1  single clock for the whole block.
- `reset`  in  1  asynchronous, active-high reset.
- `lsu_valid`  in  1  core request; sampled only while `lsu_ready`=1.
- `lsu_ready`  out  1  unit idle and accepting a request.
- `lsu_we`  in  1  1=store, 0=load.
- `lsu_funct3`  in  3  RV32I funct3:
  - loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU;
  - stores: 000 SB, 001 SH, 010 SW;
  - any other code is illegal.
- `lsu_addr`  in  32  byte address.
- `lsu_wdata`  in  32  store data, right-aligned.
- `lsu_rdata`  out  32  load result, valid with `lsu_done`.
- `lsu_done`  out  1  one-cycle completion pulse.
- `lsu_err`  out  1  qualifies `lsu_done`: illegal funct3, timeout, or trapped misalign.
- `conf_sel`  in  1  memory in configuration mode; new requests are blocked.
- `mem_wren`, `mem_rden`  out  1  one-cycle request strobes.
- `mem_addr`  out  32  word address, `{2'b00, addr[31:2]}`.
- `mem_wstrb`  out  4  byte-lane write enables.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_rdata`  in  32  memory read word, valid in the `mem_ready` cycle.
- `mem_ready`  in  1  memory completion pulse, 2 cycles after the request strobe.

## Operation
- **FSM states:** IDLE, REQ, WAIT, RESP.
- **IDLE:**
  - `lsu_ready` = ~`conf_sel`.
  - On `lsu_valid & lsu_ready`, register `we`, `funct3`, `addr`, `wdata`.
  - Illegal funct3 or trapped misalign (see Configuration): go to RESP with err=1. No memory access is made.
  - Otherwise go to REQ.
- **REQ (exactly one cycle):**
  - Drive `mem_rden` (load) or `mem_wren` (store), plus `mem_addr`, `mem_wstrb`, `mem_wdata`.
  - Go to WAIT. Strobes are never held longer than one cycle, because the memory's ready generator needs an idle cycle between requests.
- **WAIT:**
  - On `mem_ready`: capture `mem_rdata`, go to RESP.
  - Counter reaches `TIMEOUT_CYC` without `mem_ready`: go to RESP with err=1.
- **RESP:** pulse `lsu_done`, drive `lsu_rdata`/`lsu_err`, return to IDLE.
- **Store lane formation (off = addr[1:0]):**
  - SB: wstrb = 0001<<off, wdata = {4{byte}}.
  - SH: wstrb = 0011<<off, wdata = {2{half}}.
  - SW: wstrb = 1111, wdata = word.
- **Load extraction:**
  - Select byte `rdata[8*off+:8]` or half `rdata[8*off+:16]`.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - Stores return `lsu_rdata`=0.
- **`conf_sel` rising in REQ/WAIT:** the transaction in flight completes normally; only new acceptance is blocked.
- **`lsu_valid` while not ready:** ignored; the core must hold it.

## Timing
- Reset values:
  - state = IDLE;
  - `lsu_ready` = ~`conf_sel` (registered state, combinational output);
  - `lsu_done`, `lsu_err`, `mem_wren`, `mem_rden`, `mem_wstrb` = 0;
  - `lsu_rdata`, `mem_addr`, `mem_wdata` = 0.
- Accept at cycle 0. REQ strobe at cycle 1. `mem_ready` at cycle 3. `lsu_done` at cycle 4.
- Normal latency is 4 cycles. Back-to-back throughput is one access per 5 cycles: next accept earliest at cycle 5.
- Error without memory access: `lsu_done` one cycle after accept.
- Timeout: `lsu_done`+`lsu_err` at cycle 2+`TIMEOUT_CYC`.
- All outputs except `lsu_ready` are registered.
- Reset asserted mid-transaction: immediate return to IDLE. All strobes drop asynchronously and no done pulse is produced.
- `mem_ready` outside WAIT is ignored.

## Configuration
- **`LSU_MISALIGN_TRAP_EN` defined:**
  - An LH/LHU/SH with addr[0]=1, or an LW/SW with addr[1:0]≠0, completes via RESP with `lsu_err`=1, `lsu_rdata`=0, and no memory strobe.
- **Not defined:**
  - The offset is forced aligned: bit 0 cleared for halves, bits 1:0 cleared for words.
  - The access proceeds normally, with no error.

## Test plan
- SW addr 0x104, data 0xDEADBEEF → cycle 1: `mem_wren`=1, `mem_addr`=0x41, `mem_wstrb`=1111, `mem_wdata`=0xDEADBEEF. Done at cycle 4, err=0.
- SB addr 0x103, data 0x000000A5 → `mem_wstrb`=1000, `mem_wdata`=0xA5A5A5A5. Then LB 0x103 with `mem_rdata`=0xA5000000 → `lsu_rdata`=0xFFFFFFA5; LBU → 0x000000A5.
- LH addr 0x102 with `mem_rdata`=0x8001_1234 → 0xFFFF8001. LHU → 0x00008001.
- `conf_sel`=1 with `lsu_valid`=1 for 10 cycles → `lsu_ready`=0, no strobes. Drop `conf_sel` → accepted the next cycle.
- Memory model never asserts `mem_ready` → `lsu_done`=1, `lsu_err`=1 at cycle 17 (default). Strobe lasts one cycle only.
- LW addr 0x102:
  - with `LSU_MISALIGN_TRAP_EN`: done at cycle 1, err=1, no `mem_rden`;
  - without it: `mem_addr`=0x40, err=0, done at cycle 4.
  - Also assert `reset` during WAIT → all outputs 0, state IDLE, no `lsu_done`.
